// File: rtl/mux_shift_register.sv
// Universal shift register built from mux-fed D flip-flops.
// Each bit is a 4:1 mux (two levels of 2:1 muxes) driving one flop.
// A shift counter marks every completed WIDTH-bit serial word, so the
// block can deserialize a serial stream in either direction.

// Single 2:1 mux cell; the 4:1 selector is composed from these.
module msr_mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// One register bit: 4:1 mux tree (hold / shr / shl / load) into a flop.
module msr_bit_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel,
  input  logic       d_hold,
  input  logic       d_shr,
  input  logic       d_shl,
  input  logic       d_load,
  output logic       q
);
  logic lo_y, hi_y, d_nxt;

  // sel[0] picks within each pair, sel[1] picks the pair
  msr_mux2 u_lo  (.a(d_hold), .b(d_shr),  .sel(sel[0]), .y(lo_y));
  msr_mux2 u_hi  (.a(d_shl),  .b(d_load), .sel(sel[0]), .y(hi_y));
  msr_mux2 u_out (.a(lo_y),   .b(hi_y),   .sel(sel[1]), .y(d_nxt));

  // Bit flop with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d_nxt;
  end
endmodule

module mux_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_valid
);
  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Neighbour taps feeding each bit's shift inputs
  logic [WIDTH-1:0] shr_in, shl_in;
  assign shr_in = {sin_r, q[WIDTH-1:1]};
  assign shl_in = {q[WIDTH-2:0], sin_l};

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      msr_bit_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .sel   (mode),
        .d_hold(q[i]),
        .d_shr (shr_in[i]),
        .d_shl (shl_in[i]),
        .d_load(pin[i]),
        .q     (q[i])
      );
    end
  endgenerate

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  // Direction of the current shift: 0 = right, 1 = left
  logic dir, last_dir, is_shift;
  assign is_shift = (mode == M_SHR) || (mode == M_SHL);
  assign dir      = (mode == M_SHL);

  // Word counter: restarts on direction change, pulses word_valid when
  // the WIDTH-th same-direction shift lands, pauses across holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cnt  <= '0;
      word_valid <= 1'b0;
      last_dir   <= 1'b0;
    end else if (is_shift) begin
      if (dir != last_dir) begin
        shift_cnt  <= CNT_W'(1);
        last_dir   <= dir;
        word_valid <= 1'b0;
      end else if (shift_cnt == CNT_LAST) begin
        shift_cnt  <= '0;
        word_valid <= 1'b1;
      end else begin
        shift_cnt  <= shift_cnt + CNT_W'(1);
        word_valid <= 1'b0;
      end
    end else if (mode == M_LOAD) begin
      shift_cnt  <= '0;
      word_valid <= 1'b0;
    end else begin
      // M_HOLD: keep count and direction
      word_valid <= 1'b0;
    end
  end

endmodule
